// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - MIPS decode-stage opcode, funct, field and control encodings
package decode_pkg;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10,
    EXT_RSVD = 2'b11
  } ext_op_e;

  typedef enum logic [1:0] {
    NPC_PC4    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JREG   = 2'b11
  } npc_sel_e;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - branch condition evaluation on forwarded rs/rt values
module branch_cmp
  import decode_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BLEZ: taken = ($signed(rs_val) <= 32'sd0);
      OP_BGTZ: taken = ($signed(rs_val) >  32'sd0);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_ext.sv
// rtl/imm_ext.sv - 16-bit immediate extender (zero, sign, lui)
module imm_ext
  import decode_pkg::*;
(
  input  logic [1:0]  ext_op,
  input  logic [15:0] imm,
  output logic [31:0] ext
);

  always_comb begin
    ext = {16'b0, imm};
    case (ext_op)
      EXT_SIGN: ext = {{16{imm[15]}}, imm};
      EXT_LUI:  ext = {imm, 16'b0};
      default:  ext = {16'b0, imm};
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - decode-stage control, immediate extend, branch compare and D/E register
module decode_unit
  import decode_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        FlushE,
  input  logic [31:0] IRD,
  input  logic [31:0] RsD,
  input  logic [31:0] RtD,
  output logic [1:0]  ExtOp,
  output logic [1:0]  NPC_Sel,
  output logic        NPCOp,
  output logic        Branch,
  output logic [31:0] Ext,
  output logic [31:0] IRE,
  output logic [31:0] EXTE
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = IRD[OP_MSB:OP_LSB];
  assign funct = IRD[FUNCT_MSB:FUNCT_LSB];

  always_comb begin
    ExtOp = EXT_ZERO;
    case (op)
      OP_ADDIU, OP_SLTI, OP_LW, OP_SW, OP_LB, OP_SB,
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ExtOp = EXT_SIGN;
      OP_LUI:                           ExtOp = EXT_LUI;
      default:                          ExtOp = EXT_ZERO;
    endcase
  end

  always_comb begin
    NPC_Sel = NPC_PC4;
    case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: NPC_Sel = NPC_BRANCH;
      OP_J, OP_JAL:                     NPC_Sel = NPC_JUMP;
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR)
          NPC_Sel = NPC_JREG;
      end
      default:                          NPC_Sel = NPC_PC4;
    endcase
  end

  assign NPCOp = (op == OP_J) || (op == OP_JAL);

  imm_ext u_imm_ext (
    .ext_op (ExtOp),
    .imm    (IRD[IMM_MSB:IMM_LSB]),
    .ext    (Ext)
  );

  branch_cmp u_branch_cmp (
    .op     (op),
    .rs_val (RsD),
    .rt_val (RtD),
    .taken  (Branch)
  );

  // A flush loads the all-zero instruction, which the execute stage treats as a nop.
  always_ff @(posedge Clk) begin
    if (Reset || FlushE) begin
      IRE  <= '0;
      EXTE <= '0;
    end else begin
      IRE  <= IRD;
      EXTE <= Ext;
    end
  end

endmodule

// File: tb/tb_decode_unit.sv
// tb/tb_decode_unit.sv - table-driven check of decode_unit plus flush/reset sequences
module tb_decode_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        FlushE;
  logic [31:0] IRD;
  logic [31:0] RsD;
  logic [31:0] RtD;
  logic [1:0]  ExtOp;
  logic [1:0]  NPC_Sel;
  logic        NPCOp;
  logic        Branch;
  logic [31:0] Ext;
  logic [31:0] IRE;
  logic [31:0] EXTE;

  int errors = 0;
  int checks = 0;

  decode_unit dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .FlushE  (FlushE),
    .IRD     (IRD),
    .RsD     (RsD),
    .RtD     (RtD),
    .ExtOp   (ExtOp),
    .NPC_Sel (NPC_Sel),
    .NPCOp   (NPCOp),
    .Branch  (Branch),
    .Ext     (Ext),
    .IRE     (IRE),
    .EXTE    (EXTE)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] ird;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [1:0]  ext_op;
    logic [1:0]  npc_sel;
    logic        npc_op;
    logic        branch;
    logic [31:0] ext;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [31:0] ird, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [1:0] eo, input logic [1:0] ns,
                     input logic no, input logic br, input logic [31:0] ex);
    vec_t v;
    v.name = n; v.ird = ird; v.rs = rs; v.rt = rt;
    v.ext_op = eo; v.npc_sel = ns; v.npc_op = no; v.branch = br; v.ext = ex;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [31:0] ird, input logic rst, input logic fl);
    @(negedge Clk);
    IRD = ird; Reset = rst; FlushE = fl;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //   name          IRD           RsD           RtD           ExtOp NPC   NPCOp Br   Ext
    add("ori",        32'h3421_8001, 32'd0,        32'd0,        2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_8001);
    add("lw",         32'h8C22_FFFC, 32'd0,        32'd0,        2'b01, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFC);
    add("lui",        32'h3C01_1234, 32'd0,        32'd0,        2'b10, 2'b00, 1'b0, 1'b0, 32'h1234_0000);
    add("beq_eq",     32'h1000_0003, 32'd5,        32'd5,        2'b01, 2'b01, 1'b0, 1'b1, 32'h0000_0003);
    add("beq_ne",     32'h1000_0003, 32'd5,        32'd6,        2'b01, 2'b01, 1'b0, 1'b0, 32'h0000_0003);
    add("bgtz_neg",   32'h1C00_0004, 32'h8000_0000, 32'd0,       2'b01, 2'b01, 1'b0, 1'b0, 32'h0000_0004);
    add("blez_neg",   32'h1800_0004, 32'h8000_0000, 32'd0,       2'b01, 2'b01, 1'b0, 1'b1, 32'h0000_0004);
    add("bne_3_4",    32'h1400_0004, 32'd3,        32'd4,        2'b01, 2'b01, 1'b0, 1'b1, 32'h0000_0004);
    add("bne_eq",     32'h1400_FFFF, 32'd7,        32'd7,        2'b01, 2'b01, 1'b0, 1'b0, 32'hFFFF_FFFF);
    add("blez_zero",  32'h1800_0004, 32'd0,        32'd0,        2'b01, 2'b01, 1'b0, 1'b1, 32'h0000_0004);
    add("bgtz_zero",  32'h1C00_0004, 32'd0,        32'd0,        2'b01, 2'b01, 1'b0, 1'b0, 32'h0000_0004);
    add("bgtz_one",   32'h1C00_0004, 32'd1,        32'd0,        2'b01, 2'b01, 1'b0, 1'b1, 32'h0000_0004);
    add("blez_pos",   32'h1800_0004, 32'h7FFF_FFFF, 32'd0,       2'b01, 2'b01, 1'b0, 1'b0, 32'h0000_0004);
    add("j",          32'h0800_0010, 32'd0,        32'd0,        2'b00, 2'b10, 1'b1, 1'b0, 32'h0000_0010);
    add("jal",        32'h0C00_8000, 32'd0,        32'd0,        2'b00, 2'b10, 1'b1, 1'b0, 32'h0000_8000);
    add("jr",         32'h03E0_0008, 32'd9,        32'd9,        2'b00, 2'b11, 1'b0, 1'b0, 32'h0000_0008);
    add("jalr",       32'h0060_F809, 32'd0,        32'd0,        2'b00, 2'b11, 1'b0, 1'b0, 32'h0000_F809);
    add("addu_rtype", 32'h0022_1821, 32'd0,        32'd0,        2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_1821);
    add("nop",        32'h0000_0000, 32'd1,        32'd1,        2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_0000);
    add("andi_neg",   32'h3000_8000, 32'd0,        32'd0,        2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_8000);
    add("xori",       32'h3800_F000, 32'd0,        32'd0,        2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_F000);
    add("addiu_neg",  32'h2400_8000, 32'd0,        32'd0,        2'b01, 2'b00, 1'b0, 1'b0, 32'hFFFF_8000);
    add("slti",       32'h2800_FFFE, 32'd0,        32'd0,        2'b01, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFE);
    add("sw",         32'hAC22_8004, 32'd0,        32'd0,        2'b01, 2'b00, 1'b0, 1'b0, 32'hFFFF_8004);
    add("lb",         32'h8000_0010, 32'd0,        32'd0,        2'b01, 2'b00, 1'b0, 1'b0, 32'h0000_0010);
    add("sb",         32'hA000_FFF0, 32'd0,        32'd0,        2'b01, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFF0);
    add("illegal",    32'hFC00_FFFF, 32'd5,        32'd5,        2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_FFFF);

    Reset = 1'b1; FlushE = 1'b0; IRD = 32'h3421_8001; RsD = '0; RtD = '0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("reset_IRE", IRE, 32'h0);
    check("reset_EXTE", EXTE, 32'h0);

    @(negedge Clk);
    Reset = 1'b0;
    foreach (vecs[i]) begin
      @(negedge Clk);
      IRD = vecs[i].ird; RsD = vecs[i].rs; RtD = vecs[i].rt;
      #1;
      check({vecs[i].name, "_ExtOp"},   {30'b0, ExtOp},   {30'b0, vecs[i].ext_op});
      check({vecs[i].name, "_NPC_Sel"}, {30'b0, NPC_Sel}, {30'b0, vecs[i].npc_sel});
      check({vecs[i].name, "_NPCOp"},   {31'b0, NPCOp},   {31'b0, vecs[i].npc_op});
      check({vecs[i].name, "_Branch"},  {31'b0, Branch},  {31'b0, vecs[i].branch});
      check({vecs[i].name, "_Ext"},     Ext,              vecs[i].ext);
      @(posedge Clk); #1;
      check({vecs[i].name, "_IRE"},  IRE,  vecs[i].ird);
      check({vecs[i].name, "_EXTE"}, EXTE, vecs[i].ext);
    end

    // Flush bubble, then recovery once FlushE drops.
    step(32'h8C22_FFFC, 1'b0, 1'b0);
    check("pre_flush_IRE", IRE, 32'h8C22_FFFC);
    step(32'h3421_8001, 1'b0, 1'b1);
    check("flush_IRE", IRE, 32'h0);
    check("flush_EXTE", EXTE, 32'h0);
    check("flush_comb_Ext", Ext, 32'h0000_8001);
    step(32'h3421_8001, 1'b0, 1'b0);
    check("unflush_IRE", IRE, 32'h3421_8001);
    check("unflush_EXTE", EXTE, 32'h0000_8001);

    // Reset mid-stream, then both asserted together.
    step(32'h3C01_1234, 1'b1, 1'b0);
    check("midreset_IRE", IRE, 32'h0);
    check("midreset_EXTE", EXTE, 32'h0);
    step(32'h3C01_1234, 1'b0, 1'b0);
    check("postreset_EXTE", EXTE, 32'h1234_0000);
    step(32'h8C22_FFFC, 1'b1, 1'b1);
    check("both_IRE", IRE, 32'h0);
    check("both_EXTE", EXTE, 32'h0);
    step(32'h8C22_FFFC, 1'b0, 1'b0);
    check("after_both_EXTE", EXTE, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
